// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 tables, GF(2^8) helpers, round and key-schedule
// functions shared by the iterative inverse cipher.
package aes_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_KEXP  = 2'd1;
   localparam logic [1:0] ST_INIT  = 2'd2;
   localparam logic [1:0] ST_ROUND = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_KEXP  = ST_KEXP,
      S_INIT  = ST_INIT,
      S_ROUND = ST_ROUND
   } state_e;

   function automatic logic [31:0] rcon(input logic [3:0] i);
      logic [7:0] b;
      case (i)
         4'd0: b = 8'h01;
         4'd1: b = 8'h02;
         4'd2: b = 8'h04;
         4'd3: b = 8'h08;
         4'd4: b = 8'h10;
         4'd5: b = 8'h20;
         4'd6: b = 8'h40;
         4'd7: b = 8'h80;
         4'd8: b = 8'h1b;
         4'd9: b = 8'h36;
         default: b = 8'h00;
      endcase
      return {b, 24'h0};
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] y;
      y = '0;
      case (x)
         8'h00:y=8'h63; 8'h01:y=8'h7c; 8'h02:y=8'h77; 8'h03:y=8'h7b; 8'h04:y=8'hf2; 8'h05:y=8'h6b; 8'h06:y=8'h6f; 8'h07:y=8'hc5;
         8'h08:y=8'h30; 8'h09:y=8'h01; 8'h0a:y=8'h67; 8'h0b:y=8'h2b; 8'h0c:y=8'hfe; 8'h0d:y=8'hd7; 8'h0e:y=8'hab; 8'h0f:y=8'h76;
         8'h10:y=8'hca; 8'h11:y=8'h82; 8'h12:y=8'hc9; 8'h13:y=8'h7d; 8'h14:y=8'hfa; 8'h15:y=8'h59; 8'h16:y=8'h47; 8'h17:y=8'hf0;
         8'h18:y=8'had; 8'h19:y=8'hd4; 8'h1a:y=8'ha2; 8'h1b:y=8'haf; 8'h1c:y=8'h9c; 8'h1d:y=8'ha4; 8'h1e:y=8'h72; 8'h1f:y=8'hc0;
         8'h20:y=8'hb7; 8'h21:y=8'hfd; 8'h22:y=8'h93; 8'h23:y=8'h26; 8'h24:y=8'h36; 8'h25:y=8'h3f; 8'h26:y=8'hf7; 8'h27:y=8'hcc;
         8'h28:y=8'h34; 8'h29:y=8'ha5; 8'h2a:y=8'he5; 8'h2b:y=8'hf1; 8'h2c:y=8'h71; 8'h2d:y=8'hd8; 8'h2e:y=8'h31; 8'h2f:y=8'h15;
         8'h30:y=8'h04; 8'h31:y=8'hc7; 8'h32:y=8'h23; 8'h33:y=8'hc3; 8'h34:y=8'h18; 8'h35:y=8'h96; 8'h36:y=8'h05; 8'h37:y=8'h9a;
         8'h38:y=8'h07; 8'h39:y=8'h12; 8'h3a:y=8'h80; 8'h3b:y=8'he2; 8'h3c:y=8'heb; 8'h3d:y=8'h27; 8'h3e:y=8'hb2; 8'h3f:y=8'h75;
         8'h40:y=8'h09; 8'h41:y=8'h83; 8'h42:y=8'h2c; 8'h43:y=8'h1a; 8'h44:y=8'h1b; 8'h45:y=8'h6e; 8'h46:y=8'h5a; 8'h47:y=8'ha0;
         8'h48:y=8'h52; 8'h49:y=8'h3b; 8'h4a:y=8'hd6; 8'h4b:y=8'hb3; 8'h4c:y=8'h29; 8'h4d:y=8'he3; 8'h4e:y=8'h2f; 8'h4f:y=8'h84;
         8'h50:y=8'h53; 8'h51:y=8'hd1; 8'h52:y=8'h00; 8'h53:y=8'hed; 8'h54:y=8'h20; 8'h55:y=8'hfc; 8'h56:y=8'hb1; 8'h57:y=8'h5b;
         8'h58:y=8'h6a; 8'h59:y=8'hcb; 8'h5a:y=8'hbe; 8'h5b:y=8'h39; 8'h5c:y=8'h4a; 8'h5d:y=8'h4c; 8'h5e:y=8'h58; 8'h5f:y=8'hcf;
         8'h60:y=8'hd0; 8'h61:y=8'hef; 8'h62:y=8'haa; 8'h63:y=8'hfb; 8'h64:y=8'h43; 8'h65:y=8'h4d; 8'h66:y=8'h33; 8'h67:y=8'h85;
         8'h68:y=8'h45; 8'h69:y=8'hf9; 8'h6a:y=8'h02; 8'h6b:y=8'h7f; 8'h6c:y=8'h50; 8'h6d:y=8'h3c; 8'h6e:y=8'h9f; 8'h6f:y=8'ha8;
         8'h70:y=8'h51; 8'h71:y=8'ha3; 8'h72:y=8'h40; 8'h73:y=8'h8f; 8'h74:y=8'h92; 8'h75:y=8'h9d; 8'h76:y=8'h38; 8'h77:y=8'hf5;
         8'h78:y=8'hbc; 8'h79:y=8'hb6; 8'h7a:y=8'hda; 8'h7b:y=8'h21; 8'h7c:y=8'h10; 8'h7d:y=8'hff; 8'h7e:y=8'hf3; 8'h7f:y=8'hd2;
         8'h80:y=8'hcd; 8'h81:y=8'h0c; 8'h82:y=8'h13; 8'h83:y=8'hec; 8'h84:y=8'h5f; 8'h85:y=8'h97; 8'h86:y=8'h44; 8'h87:y=8'h17;
         8'h88:y=8'hc4; 8'h89:y=8'ha7; 8'h8a:y=8'h7e; 8'h8b:y=8'h3d; 8'h8c:y=8'h64; 8'h8d:y=8'h5d; 8'h8e:y=8'h19; 8'h8f:y=8'h73;
         8'h90:y=8'h60; 8'h91:y=8'h81; 8'h92:y=8'h4f; 8'h93:y=8'hdc; 8'h94:y=8'h22; 8'h95:y=8'h2a; 8'h96:y=8'h90; 8'h97:y=8'h88;
         8'h98:y=8'h46; 8'h99:y=8'hee; 8'h9a:y=8'hb8; 8'h9b:y=8'h14; 8'h9c:y=8'hde; 8'h9d:y=8'h5e; 8'h9e:y=8'h0b; 8'h9f:y=8'hdb;
         8'ha0:y=8'he0; 8'ha1:y=8'h32; 8'ha2:y=8'h3a; 8'ha3:y=8'h0a; 8'ha4:y=8'h49; 8'ha5:y=8'h06; 8'ha6:y=8'h24; 8'ha7:y=8'h5c;
         8'ha8:y=8'hc2; 8'ha9:y=8'hd3; 8'haa:y=8'hac; 8'hab:y=8'h62; 8'hac:y=8'h91; 8'had:y=8'h95; 8'hae:y=8'he4; 8'haf:y=8'h79;
         8'hb0:y=8'he7; 8'hb1:y=8'hc8; 8'hb2:y=8'h37; 8'hb3:y=8'h6d; 8'hb4:y=8'h8d; 8'hb5:y=8'hd5; 8'hb6:y=8'h4e; 8'hb7:y=8'ha9;
         8'hb8:y=8'h6c; 8'hb9:y=8'h56; 8'hba:y=8'hf4; 8'hbb:y=8'hea; 8'hbc:y=8'h65; 8'hbd:y=8'h7a; 8'hbe:y=8'hae; 8'hbf:y=8'h08;
         8'hc0:y=8'hba; 8'hc1:y=8'h78; 8'hc2:y=8'h25; 8'hc3:y=8'h2e; 8'hc4:y=8'h1c; 8'hc5:y=8'ha6; 8'hc6:y=8'hb4; 8'hc7:y=8'hc6;
         8'hc8:y=8'he8; 8'hc9:y=8'hdd; 8'hca:y=8'h74; 8'hcb:y=8'h1f; 8'hcc:y=8'h4b; 8'hcd:y=8'hbd; 8'hce:y=8'h8b; 8'hcf:y=8'h8a;
         8'hd0:y=8'h70; 8'hd1:y=8'h3e; 8'hd2:y=8'hb5; 8'hd3:y=8'h66; 8'hd4:y=8'h48; 8'hd5:y=8'h03; 8'hd6:y=8'hf6; 8'hd7:y=8'h0e;
         8'hd8:y=8'h61; 8'hd9:y=8'h35; 8'hda:y=8'h57; 8'hdb:y=8'hb9; 8'hdc:y=8'h86; 8'hdd:y=8'hc1; 8'hde:y=8'h1d; 8'hdf:y=8'h9e;
         8'he0:y=8'he1; 8'he1:y=8'hf8; 8'he2:y=8'h98; 8'he3:y=8'h11; 8'he4:y=8'h69; 8'he5:y=8'hd9; 8'he6:y=8'h8e; 8'he7:y=8'h94;
         8'he8:y=8'h9b; 8'he9:y=8'h1e; 8'hea:y=8'h87; 8'heb:y=8'he9; 8'hec:y=8'hce; 8'hed:y=8'h55; 8'hee:y=8'h28; 8'hef:y=8'hdf;
         8'hf0:y=8'h8c; 8'hf1:y=8'ha1; 8'hf2:y=8'h89; 8'hf3:y=8'h0d; 8'hf4:y=8'hbf; 8'hf5:y=8'he6; 8'hf6:y=8'h42; 8'hf7:y=8'h68;
         8'hf8:y=8'h41; 8'hf9:y=8'h99; 8'hfa:y=8'h2d; 8'hfb:y=8'h0f; 8'hfc:y=8'hb0; 8'hfd:y=8'h54; 8'hfe:y=8'hbb; 8'hff:y=8'h16;
      endcase
      return y;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] y;
      y = '0;
      case (x)
         8'h00:y=8'h52; 8'h01:y=8'h09; 8'h02:y=8'h6a; 8'h03:y=8'hd5; 8'h04:y=8'h30; 8'h05:y=8'h36; 8'h06:y=8'ha5; 8'h07:y=8'h38;
         8'h08:y=8'hbf; 8'h09:y=8'h40; 8'h0a:y=8'ha3; 8'h0b:y=8'h9e; 8'h0c:y=8'h81; 8'h0d:y=8'hf3; 8'h0e:y=8'hd7; 8'h0f:y=8'hfb;
         8'h10:y=8'h7c; 8'h11:y=8'he3; 8'h12:y=8'h39; 8'h13:y=8'h82; 8'h14:y=8'h9b; 8'h15:y=8'h2f; 8'h16:y=8'hff; 8'h17:y=8'h87;
         8'h18:y=8'h34; 8'h19:y=8'h8e; 8'h1a:y=8'h43; 8'h1b:y=8'h44; 8'h1c:y=8'hc4; 8'h1d:y=8'hde; 8'h1e:y=8'he9; 8'h1f:y=8'hcb;
         8'h20:y=8'h54; 8'h21:y=8'h7b; 8'h22:y=8'h94; 8'h23:y=8'h32; 8'h24:y=8'ha6; 8'h25:y=8'hc2; 8'h26:y=8'h23; 8'h27:y=8'h3d;
         8'h28:y=8'hee; 8'h29:y=8'h4c; 8'h2a:y=8'h95; 8'h2b:y=8'h0b; 8'h2c:y=8'h42; 8'h2d:y=8'hfa; 8'h2e:y=8'hc3; 8'h2f:y=8'h4e;
         8'h30:y=8'h08; 8'h31:y=8'h2e; 8'h32:y=8'ha1; 8'h33:y=8'h66; 8'h34:y=8'h28; 8'h35:y=8'hd9; 8'h36:y=8'h24; 8'h37:y=8'hb2;
         8'h38:y=8'h76; 8'h39:y=8'h5b; 8'h3a:y=8'ha2; 8'h3b:y=8'h49; 8'h3c:y=8'h6d; 8'h3d:y=8'h8b; 8'h3e:y=8'hd1; 8'h3f:y=8'h25;
         8'h40:y=8'h72; 8'h41:y=8'hf8; 8'h42:y=8'hf6; 8'h43:y=8'h64; 8'h44:y=8'h86; 8'h45:y=8'h68; 8'h46:y=8'h98; 8'h47:y=8'h16;
         8'h48:y=8'hd4; 8'h49:y=8'ha4; 8'h4a:y=8'h5c; 8'h4b:y=8'hcc; 8'h4c:y=8'h5d; 8'h4d:y=8'h65; 8'h4e:y=8'hb6; 8'h4f:y=8'h92;
         8'h50:y=8'h6c; 8'h51:y=8'h70; 8'h52:y=8'h48; 8'h53:y=8'h50; 8'h54:y=8'hfd; 8'h55:y=8'hed; 8'h56:y=8'hb9; 8'h57:y=8'hda;
         8'h58:y=8'h5e; 8'h59:y=8'h15; 8'h5a:y=8'h46; 8'h5b:y=8'h57; 8'h5c:y=8'ha7; 8'h5d:y=8'h8d; 8'h5e:y=8'h9d; 8'h5f:y=8'h84;
         8'h60:y=8'h90; 8'h61:y=8'hd8; 8'h62:y=8'hab; 8'h63:y=8'h00; 8'h64:y=8'h8c; 8'h65:y=8'hbc; 8'h66:y=8'hd3; 8'h67:y=8'h0a;
         8'h68:y=8'hf7; 8'h69:y=8'he4; 8'h6a:y=8'h58; 8'h6b:y=8'h05; 8'h6c:y=8'hb8; 8'h6d:y=8'hb3; 8'h6e:y=8'h45; 8'h6f:y=8'h06;
         8'h70:y=8'hd0; 8'h71:y=8'h2c; 8'h72:y=8'h1e; 8'h73:y=8'h8f; 8'h74:y=8'hca; 8'h75:y=8'h3f; 8'h76:y=8'h0f; 8'h77:y=8'h02;
         8'h78:y=8'hc1; 8'h79:y=8'haf; 8'h7a:y=8'hbd; 8'h7b:y=8'h03; 8'h7c:y=8'h01; 8'h7d:y=8'h13; 8'h7e:y=8'h8a; 8'h7f:y=8'h6b;
         8'h80:y=8'h3a; 8'h81:y=8'h91; 8'h82:y=8'h11; 8'h83:y=8'h41; 8'h84:y=8'h4f; 8'h85:y=8'h67; 8'h86:y=8'hdc; 8'h87:y=8'hea;
         8'h88:y=8'h97; 8'h89:y=8'hf2; 8'h8a:y=8'hcf; 8'h8b:y=8'hce; 8'h8c:y=8'hf0; 8'h8d:y=8'hb4; 8'h8e:y=8'he6; 8'h8f:y=8'h73;
         8'h90:y=8'h96; 8'h91:y=8'hac; 8'h92:y=8'h74; 8'h93:y=8'h22; 8'h94:y=8'he7; 8'h95:y=8'had; 8'h96:y=8'h35; 8'h97:y=8'h85;
         8'h98:y=8'he2; 8'h99:y=8'hf9; 8'h9a:y=8'h37; 8'h9b:y=8'he8; 8'h9c:y=8'h1c; 8'h9d:y=8'h75; 8'h9e:y=8'hdf; 8'h9f:y=8'h6e;
         8'ha0:y=8'h47; 8'ha1:y=8'hf1; 8'ha2:y=8'h1a; 8'ha3:y=8'h71; 8'ha4:y=8'h1d; 8'ha5:y=8'h29; 8'ha6:y=8'hc5; 8'ha7:y=8'h89;
         8'ha8:y=8'h6f; 8'ha9:y=8'hb7; 8'haa:y=8'h62; 8'hab:y=8'h0e; 8'hac:y=8'haa; 8'had:y=8'h18; 8'hae:y=8'hbe; 8'haf:y=8'h1b;
         8'hb0:y=8'hfc; 8'hb1:y=8'h56; 8'hb2:y=8'h3e; 8'hb3:y=8'h4b; 8'hb4:y=8'hc6; 8'hb5:y=8'hd2; 8'hb6:y=8'h79; 8'hb7:y=8'h20;
         8'hb8:y=8'h9a; 8'hb9:y=8'hdb; 8'hba:y=8'hc0; 8'hbb:y=8'hfe; 8'hbc:y=8'h78; 8'hbd:y=8'hcd; 8'hbe:y=8'h5a; 8'hbf:y=8'hf4;
         8'hc0:y=8'h1f; 8'hc1:y=8'hdd; 8'hc2:y=8'ha8; 8'hc3:y=8'h33; 8'hc4:y=8'h88; 8'hc5:y=8'h07; 8'hc6:y=8'hc7; 8'hc7:y=8'h31;
         8'hc8:y=8'hb1; 8'hc9:y=8'h12; 8'hca:y=8'h10; 8'hcb:y=8'h59; 8'hcc:y=8'h27; 8'hcd:y=8'h80; 8'hce:y=8'hec; 8'hcf:y=8'h5f;
         8'hd0:y=8'h60; 8'hd1:y=8'h51; 8'hd2:y=8'h7f; 8'hd3:y=8'ha9; 8'hd4:y=8'h19; 8'hd5:y=8'hb5; 8'hd6:y=8'h4a; 8'hd7:y=8'h0d;
         8'hd8:y=8'h2d; 8'hd9:y=8'he5; 8'hda:y=8'h7a; 8'hdb:y=8'h9f; 8'hdc:y=8'h93; 8'hdd:y=8'hc9; 8'hde:y=8'h9c; 8'hdf:y=8'hef;
         8'he0:y=8'ha0; 8'he1:y=8'he0; 8'he2:y=8'h3b; 8'he3:y=8'h4d; 8'he4:y=8'hae; 8'he5:y=8'h2a; 8'he6:y=8'hf5; 8'he7:y=8'hb0;
         8'he8:y=8'hc8; 8'he9:y=8'heb; 8'hea:y=8'hbb; 8'heb:y=8'h3c; 8'hec:y=8'h83; 8'hed:y=8'h53; 8'hee:y=8'h99; 8'hef:y=8'h61;
         8'hf0:y=8'h17; 8'hf1:y=8'h2b; 8'hf2:y=8'h04; 8'hf3:y=8'h7e; 8'hf4:y=8'hba; 8'hf5:y=8'h77; 8'hf6:y=8'hd6; 8'hf7:y=8'h26;
         8'hf8:y=8'he1; 8'hf9:y=8'h69; 8'hfa:y=8'h14; 8'hfb:y=8'h63; 8'hfc:y=8'h55; 8'hfd:y=8'h21; 8'hfe:y=8'h0c; 8'hff:y=8'h7d;
      endcase
      return y;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // c is one of 09/0b/0d/0e; any 4-bit constant works
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [3:0] c);
      logic [7:0] x2, x4, x8;
      x2 = xtime(x);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^
             (c[1] ? x2 : 8'h00) ^ (c[0] ? x : 8'h00);
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++)
         o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 32] = {
            gf_mul(a0,4'he) ^ gf_mul(a1,4'hb) ^ gf_mul(a2,4'hd) ^ gf_mul(a3,4'h9),
            gf_mul(a0,4'h9) ^ gf_mul(a1,4'he) ^ gf_mul(a2,4'hb) ^ gf_mul(a3,4'hd),
            gf_mul(a0,4'hd) ^ gf_mul(a1,4'h9) ^ gf_mul(a2,4'he) ^ gf_mul(a3,4'hb),
            gf_mul(a0,4'hb) ^ gf_mul(a1,4'hd) ^ gf_mul(a2,4'h9) ^ gf_mul(a3,4'he)};
      end
      return o;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      logic [31:0] o;
      for (int i = 0; i < 4; i++)
         o[8*i +: 8] = sbox(w[8*i +: 8]);
      return o;
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [31:0] rc);
      logic [31:0] w0, w1, w2, w3;
      {w0, w1, w2, w3} = k;
      w0 = w0 ^ sub_word(rot_word(w3)) ^ rc;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // undoes key_fwd: w3..w1 first, then w0 from the recovered w3
   function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [31:0] rc);
      logic [31:0] w0, w1, w2, w3;
      {w0, w1, w2, w3} = k;
      w3 = w3 ^ w2;
      w2 = w2 ^ w1;
      w1 = w1 ^ w0;
      w0 = w0 ^ sub_word(rot_word(w3)) ^ rc;
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// aes_inv_cipher_iter_if: start/busy/done request bundle for the
// iterative AES-128 inverse cipher.
interface aes_inv_cipher_iter_if;
   logic         start;
   logic         key_is_last;
   logic [127:0] datain;
   logic [127:0] key;
   logic [127:0] dataout;
   logic [127:0] keylast;
   logic         busy;
   logic         done;

   modport master (
      output start, key_is_last, datain, key,
      input  dataout, keylast, busy, done
   );

   modport slave (
      input  start, key_is_last, datain, key,
      output dataout, keylast, busy, done
   );
endinterface

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round; the final round
// skips InvMixColumns.
module aes_inv_round (
   input  logic [127:0] st_i,
   input  logic [127:0] kp_i,
   input  logic         last_i,
   output logic [127:0] nxt_o
);
   import aes_pkg::*;

   logic [127:0] t;

   assign t     = inv_sub_bytes(inv_shift_rows(st_i)) ^ kp_i;
   assign nxt_o = last_i ? t : inv_mix_columns(t);
endmodule

// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES-128 decryptor, one inverse round
// per clock, optional forward key expansion from the cipher key.
module aes_inv_cipher_iter (
   input  logic                  clk,
   input  logic                  rst,
   aes_inv_cipher_iter_if.slave  bus
);
   import aes_pkg::*;

   state_e       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [127:0] ct_q, ct_d;
   logic [127:0] key_q, key_d;
   logic [127:0] st_q, st_d;
   logic [127:0] dout_q, dout_d;
   logic [127:0] klast_q, klast_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic [127:0] kp;
   logic [127:0] rnd;

   // key_q walks k10 -> k0 one step per round
   assign kp = key_inv(key_q, rcon(cnt_q));

   aes_inv_round u_round (
      .st_i   (st_q),
      .kp_i   (kp),
      .last_i (cnt_q == 4'd0),
      .nxt_o  (rnd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ct_q    <= '0;
         key_q   <= '0;
         st_q    <= '0;
         dout_q  <= '0;
         klast_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ct_q    <= ct_d;
         key_q   <= key_d;
         st_q    <= st_d;
         dout_q  <= dout_d;
         klast_q <= klast_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ct_d    = ct_q;
      key_d   = key_q;
      st_d    = st_q;
      dout_d  = dout_q;
      klast_d = klast_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               ct_d    = bus.datain;
               key_d   = bus.key;
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = bus.key_is_last ? S_INIT : S_KEXP;
            end
         end
         S_KEXP: begin
            key_d = key_fwd(key_q, rcon(cnt_q));
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd9) state_d = S_INIT;
         end
         S_INIT: begin
            st_d    = ct_q ^ key_q;
            klast_d = key_q;
            cnt_d   = 4'd9;
            state_d = S_ROUND;
         end
         S_ROUND: begin
            st_d  = rnd;
            key_d = kp;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd0) begin
               dout_d  = rnd;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.dataout = dout_q;
   assign bus.keylast = klast_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb_aes_inv_cipher_iter: directed and loopback bench for the iterative
// AES-128 inverse cipher, with its own reference encryptor.
module tb_aes_inv_cipher_iter;

   localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_KL = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] B_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

   logic clk = 1'b0;
   logic rst;

   aes_inv_cipher_iter_if bus ();

   aes_inv_cipher_iter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] pt;
      logic [127:0] kl;
   } exp_t;

   exp_t       sb_q[$];
   int         ncmp = 0;
   int         nerr = 0;
   int         cyc = 0;
   int         last_done_cyc = 0;
   logic [7:0] sb_t [256];

   always @(posedge clk) cyc <= cyc + 1;

   // reference S-box built from GF(2^8) inverse plus the affine map
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] a, input int k);
      return 8'((a << k) | (a >> (8 - k)));
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] a);
      return a ^ rl(a, 1) ^ rl(a, 2) ^ rl(a, 3) ^ rl(a, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] encrypt(input logic [127:0] pt,
                                            input logic [127:0] k0,
                                            output logic [127:0] k10);
      logic [127:0] s, k, t;
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [31:0]  w0, w1, w2, w3, tw;
      s  = pt ^ k0;
      k  = k0;
      rc = 8'h01;
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++)
            s[127-8*i -: 8] = sb_t[s[127-8*i -: 8]];
         t = s;
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++)
               s[127-8*(4*c+q) -: 8] = t[127-8*(4*((c+q)%4)+q) -: 8];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[127-32*c -: 8];
               a1 = s[119-32*c -: 8];
               a2 = s[111-32*c -: 8];
               a3 = s[103-32*c -: 8];
               s[127-32*c -: 32] = {
                  gm(a0,8'h02) ^ gm(a1,8'h03) ^ a2 ^ a3,
                  a0 ^ gm(a1,8'h02) ^ gm(a2,8'h03) ^ a3,
                  a0 ^ a1 ^ gm(a2,8'h02) ^ gm(a3,8'h03),
                  gm(a0,8'h03) ^ a1 ^ a2 ^ gm(a3,8'h02)};
            end
         end
         {w0, w1, w2, w3} = k;
         tw = {sb_t[w3[23:16]], sb_t[w3[15:8]], sb_t[w3[7:0]], sb_t[w3[31:24]]};
         w0 = w0 ^ tw ^ {rc, 24'h0};
         w1 = w1 ^ w0;
         w2 = w2 ^ w1;
         w3 = w3 ^ w2;
         k  = {w0, w1, w2, w3};
         s  = s ^ k;
         rc = gm(rc, 8'h02);
      end
      k10 = k;
      return s;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [127:0] k, input logic [127:0] d,
                           input logic kl, input logic [127:0] p,
                           input logic [127:0] x, input string tag);
      exp_t e;
      bus.start       = 1'b1;
      bus.key         = k;
      bus.datain      = d;
      bus.key_is_last = kl;
      e.pt = p;
      e.kl = x;
      sb_q.push_back(e);
      step();
      bus.start = 1'b0;
      chk({tag, "_busy_on_accept"}, 128'(bus.busy), 128'(1));
      chk({tag, "_done_low_on_accept"}, 128'(bus.done), 128'(0));
   endtask

   // inputs are scrambled every cycle while busy; inj>0 pulses start
   // on that edge after accept
   task automatic finish_op(input string tag, input int lat, input int inj,
                            input bit post, output int n);
      bit   seen, bok;
      exp_t e;
      seen = 1'b0;
      bok  = 1'b1;
      n    = 0;
      while (!seen && n < 64) begin
         bus.start       = (n + 1 == inj);
         bus.datain      = rnd128();
         bus.key         = rnd128();
         bus.key_is_last = 1'($urandom_range(0, 1));
         step();
         n++;
         bus.start = 1'b0;
         if (bus.done === 1'b1) seen = 1'b1;
         else if (bus.busy !== 1'b1) bok = 1'b0;
      end
      chk({tag, "_done_seen"}, 128'(seen), 128'(1));
      chk({tag, "_latency"}, 128'(n), 128'(lat));
      chk({tag, "_busy_held"}, 128'(bok), 128'(1));
      if (seen) begin
         last_done_cyc = cyc;
         chk({tag, "_busy_low_at_done"}, 128'(bus.busy), 128'(0));
         chk({tag, "_sb_depth"}, 128'(sb_q.size()), 128'(1));
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_dataout"}, bus.dataout, e.pt);
            chk({tag, "_keylast"}, bus.keylast, e.kl);
         end
      end else begin
         sb_q.delete();
      end
      if (post) begin
         step();
         chk({tag, "_done_one_cycle"}, 128'(bus.done), 128'(0));
         chk({tag, "_idle_busy"}, 128'(bus.busy), 128'(0));
      end
   endtask

   task automatic no_done(input string tag, input int ncyc);
      int hits;
      hits = 0;
      for (int i = 0; i < ncyc; i++) begin
         step();
         if (bus.done !== 1'b0) hits++;
      end
      chk({tag, "_no_done"}, 128'(hits), 128'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] pt, k, ct, k10;
      int           n, d0;
      bus.start       = 1'b0;
      bus.key_is_last = 1'b0;
      bus.datain      = '0;
      bus.key         = '0;
      rst             = 1'b1;
      for (int x = 0; x < 256; x++) begin
         logic [7:0] iv;
         iv = '0;
         for (int y = 1; y < 256; y++)
            if (gm(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
         sb_t[x] = affine(iv);
      end

      step();
      step();
      chk("reset_busy", 128'(bus.busy), 128'(0));
      chk("reset_done", 128'(bus.done), 128'(0));
      chk("reset_dataout", bus.dataout, '0);
      chk("reset_keylast", bus.keylast, '0);
      rst = 1'b0;
      step();

      start_op(C1_K, C1_CT, 1'b0, C1_PT, C1_KL, "c1");
      finish_op("c1", 21, -1, 1'b1, n);

      start_op(B_K10, B_CT, 1'b1, B_PT, B_K10, "appb");
      finish_op("appb", 11, -1, 1'b1, n);

      start_op(C1_K, C1_CT, 1'b0, C1_PT, C1_KL, "busy_start");
      finish_op("busy_start", 21, 5, 1'b1, n);
      no_done("busy_start", 30);

      start_op(C1_K, C1_CT, 1'b0, C1_PT, C1_KL, "rst_mid");
      for (int i = 1; i < 15; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb_q.delete();
      chk("rst_mid_busy", 128'(bus.busy), 128'(0));
      chk("rst_mid_done", 128'(bus.done), 128'(0));
      chk("rst_mid_dataout", bus.dataout, '0);
      chk("rst_mid_keylast", bus.keylast, '0);
      no_done("rst_mid", 30);
      start_op(C1_K, C1_CT, 1'b0, C1_PT, C1_KL, "rst_fresh");
      finish_op("rst_fresh", 21, -1, 1'b1, n);

      start_op(C1_K, C1_CT, 1'b0, C1_PT, C1_KL, "b2b_a");
      finish_op("b2b_a", 21, -1, 1'b0, n);
      d0 = last_done_cyc;
      pt = rnd128();
      k  = rnd128();
      ct = encrypt(pt, k, k10);
      start_op(k, ct, 1'b0, pt, k10, "b2b_b");
      finish_op("b2b_b", 21, -1, 1'b1, n);
      chk("b2b_spacing", 128'(last_done_cyc - d0), 128'(22));

      for (int i = 0; i < 100; i++) begin
         pt = rnd128();
         k  = rnd128();
         ct = encrypt(pt, k, k10);
         start_op(k10, ct, 1'b1, pt, k10, "loop");
         finish_op("loop", 11, -1, 1'b1, n);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
